// File: rtl/mni_sched_ctrl.sv
// Packet-driven sequencer in front of myNodeInfo: latches packet fields, strobes en_MNI,
// waits for the node state to settle, then raises a low-energy alert or a slotted data request.
module mni_sched_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int MAX_SLOT   = 64
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [2:0]  pkt_type,
    input  logic [15:0] pkt_hops,
    input  logic [15:0] pkt_emax,
    input  logic [15:0] pkt_emin,
    input  logic [15:0] pkt_energy,
    input  logic [15:0] pkt_chid,
    input  logic [15:0] pkt_timeslot,
    input  logic [15:0] pkt_ethresh,
    output logic        en_MNI,
    output logic [2:0]  fPktType,
    output logic [15:0] hops,
    output logic [15:0] e_max,
    output logic [15:0] e_min,
    output logic [15:0] energy,
    output logic [15:0] ch_ID,
    output logic [15:0] timeslot,
    output logic [15:0] e_threshold,
    input  logic        role,
    input  logic        low_E,
    input  logic        slot_tick,
    output logic        tx_req,
    output logic        tx_kind,
    input  logic        tx_ack,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        UPDATE    = 3'd1,
        SETTLE    = 3'd2,
        WAIT_SLOT = 3'd3,
        TX        = 3'd4
    } state_t;

    localparam int              SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [15:0]     MAX_SLOT_W  = 16'(MAX_SLOT);
    localparam logic [2:0]      TYPE_HB     = 3'b000;
    localparam logic [2:0]      TYPE_CH     = 3'b001;
    localparam logic [2:0]      TYPE_TS     = 3'b010;
    localparam logic [2:0]      TYPE_NONE   = 3'b111;

    state_t         state_r;
    logic [2:0]     type_r;
    logic [15:0]    slot_cnt_r;
    logic [SW-1:0]  settle_cnt_r;
    logic           alert_done_r;

    // A timeslot assignment is only meaningful for slots 1..MAX_SLOT.
    function automatic logic pkt_legal(input logic [2:0] t, input logic [15:0] ts);
        case (t)
            TYPE_HB, TYPE_CH: pkt_legal = 1'b1;
            TYPE_TS:          pkt_legal = (ts != 16'd0) && (ts <= MAX_SLOT_W);
            default:          pkt_legal = 1'b0;
        endcase
    endfunction

    // Sequencer state machine; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_r      <= IDLE;
            type_r       <= TYPE_NONE;
            slot_cnt_r   <= 16'd0;
            settle_cnt_r <= '0;
            alert_done_r <= 1'b0;
            pkt_ready    <= 1'b0;
            en_MNI       <= 1'b0;
            fPktType     <= TYPE_NONE;
            hops         <= 16'd0;
            e_max        <= 16'd0;
            e_min        <= 16'd0;
            energy       <= 16'd0;
            ch_ID        <= 16'd0;
            timeslot     <= 16'd0;
            e_threshold  <= 16'd0;
            tx_req       <= 1'b0;
            tx_kind      <= 1'b0;
            busy         <= 1'b0;
            drop_cnt     <= 8'd0;
        end else begin
            en_MNI <= 1'b0;
            case (state_r)
                IDLE: begin
                    pkt_ready <= 1'b1;
                    if (pkt_valid && pkt_ready) begin
                        if (pkt_legal(pkt_type, pkt_timeslot)) begin
                            hops        <= pkt_hops;
                            e_max       <= pkt_emax;
                            e_min       <= pkt_emin;
                            energy      <= pkt_energy;
                            ch_ID       <= pkt_chid;
                            timeslot    <= pkt_timeslot;
                            e_threshold <= pkt_ethresh;
                            fPktType    <= pkt_type;
                            type_r      <= pkt_type;
                            en_MNI      <= 1'b1;
                            pkt_ready   <= 1'b0;
                            busy        <= 1'b1;
                            state_r     <= UPDATE;
                        end else if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
                    end
                end
                UPDATE: begin
                    fPktType     <= TYPE_NONE;
                    settle_cnt_r <= '0;
                    state_r      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        if (!low_E) begin
                            alert_done_r <= 1'b0;
                        end
                        // The alert outranks (and discards) a pending slot assignment.
                        if (low_E && !alert_done_r) begin
                            alert_done_r <= 1'b1;
                            tx_req       <= 1'b1;
                            tx_kind      <= 1'b1;
                            state_r      <= TX;
                        end else if ((type_r == TYPE_TS) && !role) begin
                            slot_cnt_r <= timeslot;
                            state_r    <= WAIT_SLOT;
                        end else begin
                            pkt_ready <= 1'b1;
                            busy      <= 1'b0;
                            state_r   <= IDLE;
                        end
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SW'(1);
                    end
                end
                WAIT_SLOT: begin
                    if (slot_tick) begin
                        slot_cnt_r <= slot_cnt_r - 16'd1;
                        if (slot_cnt_r == 16'd1) begin
                            tx_req  <= 1'b1;
                            tx_kind <= 1'b0;
                            state_r <= TX;
                        end
                    end
                end
                TX: begin
                    if (tx_ack) begin
                        tx_req    <= 1'b0;
                        pkt_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    tx_req    <= 1'b0;
                    pkt_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mni_sched_ctrl.sv
// Scoreboard bench for mni_sched_ctrl: stimulus pushes expected en_MNI / tx_req events,
// a negedge monitor pops and compares them; directed checks cover state and boundaries.
module tb_mni_sched_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [2:0]  pkt_type = 3'b000;
    logic [15:0] pkt_hops = 16'd0, pkt_emax = 16'd0, pkt_emin = 16'd0, pkt_energy = 16'd0;
    logic [15:0] pkt_chid = 16'd0, pkt_timeslot = 16'd0, pkt_ethresh = 16'd0;
    logic        en_MNI;
    logic [2:0]  fPktType;
    logic [15:0] hops, e_max, e_min, energy, ch_ID, timeslot, e_threshold;
    logic        role = 1'b0, low_E = 1'b0, slot_tick = 1'b0, tx_ack = 1'b0;
    logic        tx_req, tx_kind, busy;
    logic [7:0]  drop_cnt;

    typedef struct packed {
        logic         is_tx;
        logic         kind;
        logic [2:0]   typ;
        logic [111:0] flds;
    } ev_t;

    ev_t          exp_q[$];
    ev_t          mon_e;
    logic         prev_tx = 1'b0;
    int           n_checks = 0;
    int           n_pass = 0;
    logic [111:0] dut_flds;
    logic [111:0] last_flds;

    assign dut_flds = {hops, e_max, e_min, energy, ch_ID, timeslot, e_threshold};

    mni_sched_ctrl #(.SETTLE_CYC(2), .MAX_SLOT(64)) dut (
        .clk(clk), .nrst(nrst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_type(pkt_type), .pkt_hops(pkt_hops), .pkt_emax(pkt_emax), .pkt_emin(pkt_emin),
        .pkt_energy(pkt_energy), .pkt_chid(pkt_chid), .pkt_timeslot(pkt_timeslot),
        .pkt_ethresh(pkt_ethresh), .en_MNI(en_MNI), .fPktType(fPktType), .hops(hops),
        .e_max(e_max), .e_min(e_min), .energy(energy), .ch_ID(ch_ID), .timeslot(timeslot),
        .e_threshold(e_threshold), .role(role), .low_E(low_E), .slot_tick(slot_tick),
        .tx_req(tx_req), .tx_kind(tx_kind), .tx_ack(tx_ack), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mni(input logic [2:0] t, input logic [111:0] f);
        ev_t e;
        e.is_tx = 1'b0; e.kind = 1'b0; e.typ = t; e.flds = f;
        exp_q.push_back(e);
    endtask

    task automatic push_tx(input logic k);
        ev_t e;
        e.is_tx = 1'b1; e.kind = k; e.typ = 3'b000; e.flds = '0;
        exp_q.push_back(e);
    endtask

    // Present one packet for a single accepting cycle; legal packets queue an en_MNI event.
    task automatic send(input logic [2:0] t, input logic [111:0] f, input logic legal);
        int n = 0;
        while (!pkt_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_before_send", {111'd0, pkt_ready}, 112'd1);
        pkt_valid = 1'b1;
        pkt_type = t;
        {pkt_hops, pkt_emax, pkt_emin, pkt_energy, pkt_chid, pkt_timeslot, pkt_ethresh} = f;
        if (legal) push_mni(t, f);
        tick();
        pkt_valid = 1'b0;
    endtask

    task automatic pulse_slot();
        slot_tick = 1'b1;
        tick();
        slot_tick = 1'b0;
    endtask

    // Monitor: every en_MNI cycle and every tx_req rise must match the head of the queue.
    always @(negedge clk) begin
        if (en_MNI) begin
            n_checks++;
            if (exp_q.size() == 0 || exp_q[0].is_tx) begin
                $display("FAIL mni_event: unexpected en_MNI pulse type=%0b", fPktType);
            end else begin
                n_pass++;
                mon_e = exp_q.pop_front();
                chk("mni_type", {109'd0, fPktType}, {109'd0, mon_e.typ});
                chk("mni_fields", dut_flds, mon_e.flds);
            end
        end
        if (tx_req && !prev_tx) begin
            n_checks++;
            if (exp_q.size() == 0 || !exp_q[0].is_tx) begin
                $display("FAIL tx_event: unexpected tx_req rise kind=%0b", tx_kind);
            end else begin
                n_pass++;
                mon_e = exp_q.pop_front();
                chk("tx_kind", {111'd0, tx_kind}, {111'd0, mon_e.kind});
            end
        end
        prev_tx = tx_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [111:0] HB1 = {16'd1, 16'h8000, 16'h4000, 16'h8000, 16'd0, 16'd0, 16'h3333};
    localparam logic [111:0] TS3 = {16'd2, 16'h8000, 16'h2000, 16'h6000, 16'd7, 16'd3, 16'h3333};
    localparam logic [111:0] HB2 = {16'd3, 16'h7000, 16'h1000, 16'h2000, 16'd9, 16'd0, 16'h3000};
    localparam logic [111:0] HB3 = {16'd4, 16'h7000, 16'h1000, 16'h1800, 16'd9, 16'd0, 16'h3000};
    localparam logic [111:0] HB4 = {16'd5, 16'h7000, 16'h1000, 16'h4000, 16'd9, 16'd0, 16'h3000};
    localparam logic [111:0] HB5 = {16'd6, 16'h7000, 16'h1000, 16'h1000, 16'd9, 16'd0, 16'h3000};
    localparam logic [111:0] TS0 = {16'd7, 16'h1111, 16'h2222, 16'h3333, 16'd4, 16'd0, 16'h5555};
    localparam logic [111:0] T65 = {16'd8, 16'h1111, 16'h2222, 16'h3333, 16'd4, 16'd65, 16'h5555};
    localparam logic [111:0] T64 = {16'd9, 16'h1234, 16'h0567, 16'h0890, 16'd2, 16'd64, 16'h0abc};
    localparam logic [111:0] TS1 = {16'd1, 16'h8000, 16'h2000, 16'h6000, 16'd7, 16'd1, 16'h3333};

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_pkt_ready", {111'd0, pkt_ready}, 112'd0);
        chk("rst_en_MNI", {111'd0, en_MNI}, 112'd0);
        chk("rst_fPktType", {109'd0, fPktType}, 112'd7);
        chk("rst_fields", dut_flds, 112'd0);
        chk("rst_tx", {110'd0, tx_req, tx_kind}, 112'd0);
        chk("rst_busy_drop", {103'd0, busy, drop_cnt}, 112'd0);
        nrst = 1'b0;
        tick();
        chk("ready_after_rst", {111'd0, pkt_ready}, 112'd1);

        // Heartbeat, no alert: one en_MNI cycle, back to IDLE three cycles later
        send(3'b000, HB1, 1'b1);
        chk("hb_en_high", {111'd0, en_MNI}, 112'd1);
        chk("hb_busy", {110'd0, busy, pkt_ready}, 112'd2);
        tick();
        chk("hb_en_low_type_none", {108'd0, en_MNI, fPktType}, 112'd7);
        chk("hb_fields_hold", dut_flds, HB1);
        tick();
        chk("hb_not_ready_settle", {111'd0, pkt_ready}, 112'd0);
        tick();
        chk("hb_idle_ready", {109'd0, pkt_ready, busy, tx_req}, 112'd4);

        // Timeslot 3 as member: tx after third slot_tick, held until ack
        send(3'b010, TS3, 1'b1);
        repeat (3) tick();
        chk("ts_wait_state", {109'd0, busy, pkt_ready, tx_req}, 112'd4);
        push_tx(1'b0);
        for (int i = 0; i < 3; i++) begin
            pulse_slot();
            chk("ts_tx_after_tick", {111'd0, tx_req}, (i == 2) ? 112'd1 : 112'd0);
            if (i < 2) repeat (2) tick();
        end
        repeat (5) tick();
        chk("ts_tx_held", {110'd0, tx_req, tx_kind}, 112'd2);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        chk("ts_acked_idle", {110'd0, tx_req, pkt_ready}, 112'd1);

        // Alert arm/disarm sequence
        low_E = 1'b1;
        send(3'b000, HB2, 1'b1);
        push_tx(1'b1);
        repeat (3) tick();
        chk("alert1_tx", {110'd0, tx_req, tx_kind}, 112'd3);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        send(3'b000, HB3, 1'b1);
        repeat (3) tick();
        chk("alert2_suppressed", {110'd0, tx_req, pkt_ready}, 112'd1);
        low_E = 1'b0;
        send(3'b000, HB4, 1'b1);
        repeat (3) tick();
        chk("rearm_no_tx", {111'd0, tx_req}, 112'd0);
        low_E = 1'b1;
        send(3'b000, HB5, 1'b1);
        push_tx(1'b1);
        repeat (3) tick();
        chk("alert3_tx", {110'd0, tx_req, tx_kind}, 112'd3);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        low_E = 1'b0;

        // Illegal type and out-of-range timeslots are dropped
        send(3'b101, TS3, 1'b0);
        send(3'b010, TS0, 1'b0);
        send(3'b010, T65, 1'b0);
        tick();
        chk("drop_cnt_3", {104'd0, drop_cnt}, 112'd3);
        chk("drop_fields_hold", dut_flds, HB5);
        chk("drop_idle", {108'd0, busy, fPktType}, 112'd7);

        // Timeslot 64 is the largest legal value; cluster head goes straight back to IDLE
        role = 1'b1;
        send(3'b010, T64, 1'b1);
        repeat (3) tick();
        chk("ts64_ch_idle", {110'd0, busy, pkt_ready}, 112'd1);
        chk("ts64_latched", dut_flds, T64);
        role = 1'b0;

        // Saturating drop counter: 3 + 252 = 255, then 4 more stay at 255
        pkt_type = 3'b111;
        pkt_valid = 1'b1;
        repeat (252) tick();
        chk("drop_cnt_255", {104'd0, drop_cnt}, 112'd255);
        repeat (4) tick();
        pkt_valid = 1'b0;
        chk("drop_cnt_sat", {104'd0, drop_cnt}, 112'd255);
        last_flds = dut_flds;
        chk("sat_fields_hold", last_flds, T64);

        // Reset during WAIT_SLOT with two slots remaining
        send(3'b010, TS3, 1'b1);
        repeat (3) tick();
        pulse_slot();
        nrst = 1'b1;
        tick();
        chk("rst_wait_outputs", {103'd0, pkt_ready, en_MNI, tx_req, busy, fPktType, 1'b0}, 112'd14);
        chk("rst_wait_fields", dut_flds, 112'd0);
        chk("rst_wait_drop", {104'd0, drop_cnt}, 112'd0);
        nrst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            pulse_slot();
            tick();
            chk("rst_wait_no_tx", {111'd0, tx_req}, 112'd0);
        end

        // Reset during TX
        send(3'b010, TS1, 1'b1);
        push_tx(1'b0);
        repeat (3) tick();
        pulse_slot();
        chk("tx_before_rst", {111'd0, tx_req}, 112'd1);
        nrst = 1'b1;
        tick();
        chk("rst_tx_outputs", {106'd0, en_MNI, tx_req, busy, fPktType}, 112'd7);
        chk("rst_tx_fields", dut_flds, 112'd0);
        nrst = 1'b0;
        tx_ack = 1'b1;
        repeat (2) tick();
        tx_ack = 1'b0;
        chk("rst_tx_idle", {110'd0, pkt_ready, tx_req}, 112'd2);
        for (int i = 0; i < 2; i++) begin
            pulse_slot();
            tick();
            chk("rst_tx_no_tx", {111'd0, tx_req}, 112'd0);
        end

        repeat (4) tick();
        chk("scoreboard_empty", 112'(exp_q.size()), 112'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
